// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder built from GROUP-bit carry look-ahead
// groups, one group resolved per pipeline stage with the group carry
// registered between stages. Valid/ready handshake with full backpressure:
// the whole pipeline moves together whenever the output slot is free or
// being drained.
//
// Optional feature: define PCLA_SUB_EN to add a 'sub' input that turns the
// beat into a - b (cin ignored for such beats).
//
// WIDTH must be a multiple of GROUP and at least GROUP.

module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PCLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / GROUP;

    // Pipeline registers; index k holds the state after stage k has run.
    // Stage NSTG-1 is the output register.
    logic [NSTG-1:0]  vld_q;
    logic [NSTG-1:0]  c_q;
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic             ovf_q;

    // Next-state values produced by the stage logic.
    logic [NSTG-1:0]  vld_d;
    logic [NSTG-1:0]  c_d;
    logic [WIDTH-1:0] a_d [NSTG];
    logic [WIDTH-1:0] b_d [NSTG];
    logic [WIDTH-1:0] s_d [NSTG];
    logic             ovf_d;

    // Stage inputs: the operand port for stage 0, the previous register otherwise.
    logic [NSTG-1:0]  vld_in;
    logic [NSTG-1:0]  c_in;
    logic [WIDTH-1:0] a_in [NSTG];
    logic [WIDTH-1:0] b_in [NSTG];
    logic [WIDTH-1:0] s_in [NSTG];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign advance   = !vld_q[NSTG-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[NSTG-1];
    assign sum       = s_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
    assign ovf       = ovf_q;

    // Subtraction is folded in at entry as a + ~b + 1, so the stages only add.
`ifdef PCLA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Route each stage's inputs from the port or from the preceding stage register.
    always_comb begin
        vld_in[0] = in_valid;
        c_in[0]   = cin_eff;
        a_in[0]   = a;
        b_in[0]   = b_eff;
        s_in[0]   = '0;
        for (int k = 1; k < NSTG; k++) begin
            vld_in[k] = vld_q[k-1];
            c_in[k]   = c_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
        end
    end

    // Flat generate/propagate look-ahead over one group per stage; the carry
    // into the MSB is captured on the way for the overflow flag.
    always_comb begin
        logic c;
        logic g;
        logic p;
        logic cmsb;
        logic [WIDTH-1:0] s;
        c     = 1'b0;
        g     = 1'b0;
        p     = 1'b0;
        cmsb  = 1'b0;
        s     = '0;
        ovf_d = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            c = c_in[k];
            s = s_in[k];
            for (int i = 0; i < GROUP; i++) begin
                g = a_in[k][k*GROUP+i] & b_in[k][k*GROUP+i];
                p = a_in[k][k*GROUP+i] ^ b_in[k][k*GROUP+i];
                s[k*GROUP+i] = p ^ c;
                if (k*GROUP+i == WIDTH-1) begin
                    cmsb = c;
                end
                c = g | (p & c);
            end
            vld_d[k] = vld_in[k];
            c_d[k]   = c;
            a_d[k]   = a_in[k];
            b_d[k]   = b_in[k];
            s_d[k]   = s;
        end
        ovf_d = cmsb ^ c_d[NSTG-1];
    end

    // Whole pipeline advances in lockstep; reset clears everything and wins over a handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit carry look-ahead adder.
- Splits a WIDTH-bit add into WIDTH/GROUP look-ahead groups and resolves one group per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on both sides with full backpressure.
- Used as the wide-add primitive in datapath blocks that need a high clock rate.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of GROUP and at least GROUP.
- GROUP, 4, bits per look-ahead group; generate/propagate/carry logic is flat within a group.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat is present.
- in_ready  output  1  adder accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  result beat is present.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- NSTG = WIDTH/GROUP stages; each stage has a valid bit.
- Stage k computes group k (bits k*GROUP .. k*GROUP+GROUP-1):
  - generate g = a&b, propagate p = a^b;
  - look-ahead carries c[i+1] = g[i] | p[i]&c[i];
  - carry in is cin for k = 0, otherwise the registered carry from stage k-1.
- Groups not yet summed travel forward in pipeline registers. Finished low sum bits also travel forward.
- Last stage registers sum, cout and ovf. ovf uses the carry into bit WIDTH-1.
- advance = !out_valid | out_ready; in_ready = advance.
- All stage registers load only when advance=1. When advance=0 every stage holds, including the data of invalid stages.
- A beat is accepted when in_valid & in_ready.
- Latency: an accepted beat appears on the outputs exactly NSTG cycles later if no stall occurs. Each stall cycle adds one cycle of latency.
- Throughput: one beat per cycle while out_ready stays high.
- Bubbles are not squeezed out. An invalid stage still advances only on advance=1.
- Order is preserved and no beat is dropped or duplicated.
- sum, cout and ovf are stable while out_valid=1 and out_ready=0.
- in_valid=0 with advance=1 inserts a bubble: stage-0 valid is cleared.
- Reset (rst_n=0 at a clock edge):
  - all valid bits, out_valid, sum, cout and ovf go to 0;
  - in-flight beats are discarded;
  - in_ready reads 1 in the first cycle after reset.
  - Reset takes priority over any handshake in the same cycle.
- Wrap-around: a sum of 2^WIDTH or more wraps modulo 2^WIDTH and sets cout=1.
- WIDTH == GROUP gives a single registered stage with latency 1.

Optional Feature:
- Macro PCLA_SUB_EN.
- Defined:
  - extra port sub (input, 1 bit), sampled with the operand beat and carried down the pipeline.
  - sub=1 computes a + ~b + 1, i.e. a - b; cin is ignored.
  - cout=1 means no borrow (a >= b unsigned). ovf means signed subtraction overflow.
  - sub=0 behaves as the base design.
- Not defined: the sub port does not exist and the adder only adds.

Test Plan (WIDTH=16, GROUP=4, latency 4):
- a=0x0006, b=0x000B, cin=0, then the same operands with cin=1, out_ready=1 -> sum=0x0011 then 0x0012, cout=0, ovf=0, out_valid exactly 4 cycles after each accept.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Stream of 6 back-to-back beats (a=i, b=0x1000*i, i=1..6) with out_ready held low for cycles 5-7:
  - in_ready=0 during those cycles;
  - outputs hold steady;
  - all 6 results 0x1001*i appear in order;
  - no beat is lost.
- Issue 3 beats, assert rst_n=0 for 1 cycle mid-flight -> out_valid=0 for the next 4 cycles, none of the 3 results ever appears, in_ready=1 immediately after reset.
- Alternate in_valid 1/0 with a=0x00F0, b=0x0F10, cin=1 -> results sum=0x1001 appear with out_valid alternating 1/0 at 4-cycle latency.
- With PCLA_SUB_EN defined:
  - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0;
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
